// File: rtl/ivi_pkg.sv
// Shared types and helpers for the IVI interval meter.
package ivi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_COUNT,
    S_ACCUM,
    S_DONE
  } ivi_state_e;

  // 10 ms at 200 MHz
  localparam int unsigned IVI_TIMEOUT_CYC_DEFAULT = 2000000;

  // Channel-select width; a single-bit select is kept even for tiny N_CH.
  function automatic int unsigned ivi_sel_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ivi_interval_meter_if.sv
// Result hand-off bundle between the interval meter and its consumer.
interface ivi_interval_meter_if #(
  parameter int unsigned CNT_W = 24
);
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             overflow;
  logic             timeout;

  modport master (
    output result, result_valid, overflow, timeout,
    input  result_ready
  );

  modport slave (
    input  result, result_valid, overflow, timeout,
    output result_ready
  );
endinterface

// File: rtl/ivi_edge_detect.sv
// Per-channel active-edge detector with selectable polarity.
module ivi_edge_detect #(
  parameter int unsigned N_CH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] rf_i,
  input  logic            pol_i,
  output logic [N_CH-1:0] edge_o
);

  logic [N_CH-1:0] rf_dly_q;

  // One-cycle history of every rf input.
  always_ff @(posedge clk_i) begin
    if (rst_i) rf_dly_q <= '0;
    else       rf_dly_q <= rf_i;
  end

  // pol_i=0 selects rising edges, pol_i=1 selects falling edges.
  always_comb begin
    edge_o = pol_i ? (rf_dly_q & ~rf_i) : (~rf_dly_q & rf_i);
  end

endmodule

// File: rtl/ivi_interval_meter.sv
// N-channel start/stop interval meter with power-of-two averaging,
// timeout and overflow flags, and a valid/ready result hand-off.
module ivi_interval_meter
  import ivi_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned AVG_MAX_LOG2 = 4,
  parameter int unsigned TIMEOUT_CYC  = IVI_TIMEOUT_CYC_DEFAULT,
  localparam int unsigned SEL_W       = ivi_sel_w(N_CH)
) (
  input  logic              clk_200MHz,
  input  logic              reset,
  input  logic [N_CH-1:0]   rf,
  input  logic              polarity,
  input  logic [SEL_W-1:0]  start_sel,
  input  logic [SEL_W-1:0]  stop_sel,
  input  logic [2:0]        avg_log2,
  input  logic              arm,
  output logic              busy,
  ivi_interval_meter_if.master res
);

  localparam int unsigned ACC_W = CNT_W + AVG_MAX_LOG2;
  localparam int unsigned N_W   = AVG_MAX_LOG2 + 1;
  localparam int unsigned TC_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [2:0]       AVG_MAX_L = 3'(AVG_MAX_LOG2);
  localparam logic [TC_W-1:0]  TC_LAST   = TC_W'(TIMEOUT_CYC - 1);

  ivi_state_e       state_q, state_d;
  logic [SEL_W-1:0] start_q, start_d;
  logic [SEL_W-1:0] stop_q,  stop_d;
  logic             pol_q,   pol_d;
  logic [2:0]       avg_q,   avg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] iv_q,    iv_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [N_W-1:0]   n_q,     n_d;
  logic [TC_W-1:0]  tcnt_q,  tcnt_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             ovf_q,   ovf_d;
  logic             tmo_q,   tmo_d;

  logic [N_CH-1:0]  edges;
  logic [ACC_W-1:0] acc_sum;
  logic [N_W-1:0]   n_next;
  logic [N_W-1:0]   n_target;

  ivi_edge_detect #(
    .N_CH (N_CH)
  ) u_edge (
    .clk_i  (clk_200MHz),
    .rst_i  (reset),
    .rf_i   (rf),
    .pol_i  (pol_q),
    .edge_o (edges)
  );

  // State, configuration latches, counters and output registers.
  always_ff @(posedge clk_200MHz) begin
    if (reset) begin
      state_q  <= S_IDLE;
      start_q  <= '0;
      stop_q   <= '0;
      pol_q    <= 1'b0;
      avg_q    <= '0;
      cnt_q    <= '0;
      iv_q     <= '0;
      acc_q    <= '0;
      n_q      <= '0;
      tcnt_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      pol_q    <= pol_d;
      avg_q    <= avg_d;
      cnt_q    <= cnt_d;
      iv_q     <= iv_d;
      acc_q    <= acc_d;
      n_q      <= n_d;
      tcnt_q   <= tcnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
    end
  end

  // Measurement sequencing: wait for start, count to stop, accumulate, report.
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    stop_d   = stop_q;
    pol_d    = pol_q;
    avg_d    = avg_q;
    cnt_d    = cnt_q;
    iv_d     = iv_q;
    acc_d    = acc_q;
    n_d      = n_q;
    tcnt_d   = tcnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;

    acc_sum  = acc_q + ACC_W'(iv_q);
    n_next   = n_q + N_W'(1);
    n_target = N_W'(1) << avg_q;

    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          start_d = start_sel;
          stop_d  = stop_sel;
          pol_d   = polarity;
          avg_d   = (avg_log2 > AVG_MAX_L) ? AVG_MAX_L : avg_log2;
          acc_d   = '0;
          n_d     = '0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
          tcnt_d  = '0;
          state_d = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (edges[start_q]) begin
          cnt_d   = CNT_W'(1);
          state_d = S_COUNT;
        end else if (tcnt_q == TC_LAST) begin
          tmo_d    = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          tcnt_d = tcnt_q + TC_W'(1);
        end
      end
      S_COUNT: begin
        // A stop edge landing exactly on the saturated count is still a
        // valid measurement; overflow only fires when no stop arrives.
        if (edges[stop_q]) begin
          iv_d    = cnt_q;
          state_d = S_ACCUM;
        end else if (cnt_q == CNT_MAX) begin
          ovf_d    = 1'b1;
          result_d = CNT_MAX;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACCUM: begin
        acc_d = acc_sum;
        n_d   = n_next;
        if (n_next == n_target) begin
          result_d = CNT_W'(acc_sum >> avg_q);
          state_d  = S_DONE;
        end else begin
          tcnt_d  = '0;
          state_d = S_WAIT_START;
        end
      end
      S_DONE: begin
        if (res.result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status and result outputs are decoded straight from registered state.
  always_comb begin
    busy             = (state_q != S_IDLE);
    res.result_valid = (state_q == S_DONE);
    res.result       = result_q;
    res.overflow     = ovf_q;
    res.timeout      = tmo_q;
  end

endmodule

// File: tb/tb_ivi_interval_meter.sv
// Randomised and directed checks of ivi_interval_meter against a
// measurement-level reference model (interval lists, sums and cycle stamps).
module tb_ivi_interval_meter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rf, rf2;
  logic       polarity, pol2;
  logic [1:0] start_sel, stop_sel, ss2, sp2;
  logic [2:0] avg_log2, avg2;
  logic       arm, arm2;
  logic       busy, busy2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // stimulus context shared with tick()/drive()
  bit cur_pol;
  int cur_st, cur_sp;
  bit watch;
  int early_v;

  int iv_a  [16];
  int gap_a [16];

  ivi_interval_meter_if #(.CNT_W(24)) mif ();
  ivi_interval_meter_if #(.CNT_W(8))  sif ();

  ivi_interval_meter #(
    .N_CH(4), .CNT_W(24), .AVG_MAX_LOG2(4), .TIMEOUT_CYC(1000)
  ) dut (
    .clk_200MHz (clk),
    .reset      (reset),
    .rf         (rf),
    .polarity   (polarity),
    .start_sel  (start_sel),
    .stop_sel   (stop_sel),
    .avg_log2   (avg_log2),
    .arm        (arm),
    .busy       (busy),
    .res        (mif)
  );

  ivi_interval_meter #(
    .N_CH(4), .CNT_W(8), .AVG_MAX_LOG2(4), .TIMEOUT_CYC(1000)
  ) dut_s (
    .clk_200MHz (clk),
    .reset      (reset),
    .rf         (rf2),
    .polarity   (pol2),
    .start_sel  (ss2),
    .stop_sel   (sp2),
    .avg_log2   (avg2),
    .arm        (arm2),
    .busy       (busy2),
    .res        (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock, then randomise the channels not under measurement.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++)
      if (c != cur_st && c != cur_sp) rf[c] = 1'($urandom);
    if (watch && mif.result_valid) early_v++;
  endtask

  task automatic drive(input int ch, input bit act);
    rf[ch] = act ? ~cur_pol : cur_pol;
  endtask

  task automatic wait_valid(input string tag, input int budget, output int vcyc);
    vcyc = -1;
    for (int b = 0; b < budget; b++) begin
      tick();
      if (mif.result_valid) begin
        vcyc = cyc;
        break;
      end
    end
    if (vcyc < 0) chk(tag, 0, 1);
  endtask

  task automatic accept_result(input logic [63:0] exp_res);
    mif.result_ready = 1'b1;
    tick();
    mif.result_ready = 1'b0;
    chk("valid_drop", mif.result_valid, 0);
    chk("busy_idle", busy, 0);
    chk("result_hold", mif.result, exp_res);
  endtask

  // One series: iv_a/gap_a give intervals and pre-start gaps.
  task automatic run_series(input bit p, input int st, input int sp,
                            input int avg_in, input bit extra);
    int avg_eff, nmeas, last_stop, vcyc, ng, n_hold;
    longint unsigned sum;
    logic [63:0] exp_res;
    bit coinc;
    avg_eff = (avg_in > 4) ? 4 : avg_in;
    nmeas   = 1 << avg_eff;
    sum     = 0;
    last_stop = 0;
    cur_pol = p; cur_st = st; cur_sp = sp;
    rf = p ? 4'hF : 4'h0;
    polarity = p; start_sel = 2'(st); stop_sel = 2'(sp); avg_log2 = 3'(avg_in);
    tick(); tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("busy_armed", busy, 1);
    early_v = 0;
    watch   = 1'b1;
    for (int k = 0; k < nmeas; k++) begin
      ng = (k == 0) ? gap_a[k] : gap_a[k] + 1;
      for (int j = 0; j < ng; j++) begin
        tick();
        drive(st, 1'b0);
        if (extra) begin
          if (st != sp) rf[sp] = (j == ng - 1) ? cur_pol : 1'($urandom);
          arm       = ($urandom_range(0, 7) == 0);
          start_sel = 2'($urandom);
          stop_sel  = 2'($urandom);
          polarity  = 1'($urandom);
          avg_log2  = 3'($urandom);
        end
      end
      // start edge; optionally a coincident stop edge that must be ignored
      arm = 1'b0;
      drive(st, 1'b1);
      coinc = extra && (st != sp) && (iv_a[k] >= 2) && ($urandom_range(0, 1) == 1);
      if (st != sp) drive(sp, coinc);
      tick();
      drive(st, 1'b0);
      drive(sp, 1'b0);
      repeat (iv_a[k] - 1) tick();
      drive(sp, 1'b1);
      last_stop = cyc;
      sum += longint'(iv_a[k]);
      tick();
      drive(sp, 1'b0);
      // a start edge during the accumulate cycle is lost by design
      if (extra && st != sp && k + 1 < nmeas && gap_a[k+1] >= 1) drive(st, 1'b1);
    end
    watch = 1'b0;
    wait_valid("valid_seen", 50, vcyc);
    exp_res = 64'(sum >> avg_eff);
    chk("valid_latency", vcyc, last_stop + 2);
    chk("result", mif.result, exp_res);
    chk("overflow", mif.overflow, 0);
    chk("timeout", mif.timeout, 0);
    chk("early_valid", early_v, 0);
    n_hold = $urandom_range(0, 4);
    for (int h = 0; h < n_hold; h++) begin
      if (extra) arm = 1'($urandom);
      tick();
      chk("valid_held", mif.result_valid, 1);
    end
    arm = 1'b0;
    accept_result(exp_res);
  endtask

  initial begin
    int w, vcyc, t, v, avg_in, st, sp;
    bit p;
    reset = 1'b1;
    rf = '0; rf2 = '0;
    polarity = 0; pol2 = 0;
    start_sel = 0; stop_sel = 0; ss2 = 0; sp2 = 0;
    avg_log2 = 0; avg2 = 0;
    arm = 0; arm2 = 0;
    mif.result_ready = 0; sif.result_ready = 0;
    cur_pol = 0; cur_st = 0; cur_sp = 1; watch = 0; early_v = 0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", mif.result_valid, 0);
    chk("rst_result", mif.result, 0);
    chk("rst_overflow", mif.overflow, 0);
    chk("rst_timeout", mif.timeout, 0);
    chk("rst_busy_s", busy2, 0);
    chk("rst_valid_s", sif.result_valid, 0);
    reset = 1'b0;
    tick();

    // single rising-edge measurement of 100 cycles
    iv_a[0] = 100; gap_a[0] = 0;
    run_series(1'b0, 0, 1, 0, 1'b0);

    // four-sample average 407/4
    iv_a[0] = 100; iv_a[1] = 101; iv_a[2] = 102; iv_a[3] = 104;
    gap_a[0] = 3; gap_a[1] = 5; gap_a[2] = 1; gap_a[3] = 0;
    run_series(1'b0, 1, 3, 2, 1'b0);

    // period mode, falling edges every 50 cycles
    iv_a[0] = 50; iv_a[1] = 50; gap_a[0] = 0; gap_a[1] = 48;
    run_series(1'b1, 2, 2, 1, 1'b0);

    // reset while counting aborts the series
    cur_pol = 0; cur_st = 0; cur_sp = 1; rf = '0;
    polarity = 0; start_sel = 0; stop_sel = 1; avg_log2 = 0;
    tick();
    arm = 1'b1; tick(); arm = 1'b0;
    drive(0, 1'b1); tick(); drive(0, 1'b0);
    repeat (5) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", mif.result_valid, 0);
    chk("rst_mid_result", mif.result, 0);
    drive(1, 1'b1); tick(); drive(1, 1'b0);
    v = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mif.result_valid || busy) v++;
    end
    chk("rst_mid_no_valid", v, 0);

    // avg_log2=7 clamps to 16 measurements; arm while busy is ignored
    for (int k = 0; k < 16; k++) begin
      iv_a[k]  = $urandom_range(2, 20);
      gap_a[k] = $urandom_range(0, 3);
    end
    run_series(1'b0, 3, 0, 7, 1'b1);

    // no start edge: timeout after 1000 cycles in WAIT_START
    cur_pol = 0; cur_st = 0; cur_sp = 1; rf = '0;
    polarity = 0; start_sel = 0; stop_sel = 1; avg_log2 = 0;
    tick();
    arm = 1'b1; tick(); arm = 1'b0;
    w = cyc;
    wait_valid("tmo_valid_seen", 1100, vcyc);
    chk("tmo_latency", vcyc, w + 1000);
    chk("tmo_flag", mif.timeout, 1);
    chk("tmo_result", mif.result, 0);
    chk("tmo_overflow", mif.overflow, 0);
    accept_result(0);

    // 8-bit counter saturates before a stop 300 cycles later
    rf2 = '0; pol2 = 0; ss2 = 0; sp2 = 1; avg2 = 0;
    tick();
    arm2 = 1'b1; tick(); arm2 = 1'b0;
    rf2[0] = 1'b1; t = cyc;
    tick();
    rf2[0] = 1'b0;
    vcyc = -1;
    for (int b = 0; b < 400; b++) begin
      tick();
      rf2[1] = (cyc == t + 300);
      if (sif.result_valid) begin
        vcyc = cyc;
        break;
      end
    end
    chk("ovf_latency", vcyc, t + 256);
    chk("ovf_result", sif.result, 255);
    chk("ovf_flag", sif.overflow, 1);
    chk("ovf_timeout", sif.timeout, 0);
    chk("ovf_busy", busy2, 1);
    sif.result_ready = 1'b1; tick(); sif.result_ready = 1'b0;
    chk("ovf_valid_drop", sif.result_valid, 0);
    chk("ovf_flag_hold", sif.overflow, 1);

    // randomised series
    for (int r = 0; r < 12; r++) begin
      p  = 1'($urandom);
      st = $urandom_range(0, 3);
      sp = ($urandom_range(0, 3) == 0) ? st : $urandom_range(0, 3);
      avg_in = $urandom_range(0, 7);
      for (int k = 0; k < 16; k++) begin
        iv_a[k]  = $urandom_range(2, 150);
        gap_a[k] = $urandom_range(0, 8);
      end
      run_series(p, st, sp, avg_in, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
